// File: rtl/coin_acceptor_if.sv
// Coin acceptor to vending FSM link: accepted-coin pulses, counters and the busy back-pressure.
interface coin_acceptor_if #(
  parameter int unsigned CNT_W = 8
);
  logic             busy;
  logic             have_coin5;
  logic             have_coin10;
  logic [CNT_W-1:0] coin_total;
  logic [CNT_W-1:0] reject_cnt;

  modport master (
    input  busy,
    output have_coin5,
    output have_coin10,
    output coin_total,
    output reject_cnt
  );

  modport slave (
    output busy,
    input  have_coin5,
    input  have_coin10,
    input  coin_total,
    input  reject_cnt
  );
endinterface

// File: rtl/coin_acceptor.sv
// Vending machine coin front end: synchronises and debounces the two coin keys,
// arbitrates accepted/rejected coins and keeps saturating value and reject counters.
module coin_key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_n,
  output logic press_ev
);
  localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] HELD         = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  logic [1:0]    sync_q;
  logic [1:0]    vld_q;
  logic          armed_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ev_q, ev_d;
  logic          key_up;

  assign key_up   = sync_q[1];
  assign press_ev = ev_q;

  // Two-flop synchroniser; released (high) out of reset.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_n};
    end
  end

  // The key must be seen genuinely released after reset before a press can start,
  // so a key held through reset never produces a spurious event.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      vld_q <= {vld_q[0], 1'b1};
      if (vld_q[1] && key_up) begin
        armed_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ev_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ev_q    <= ev_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ev_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (armed_q && !key_up) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (key_up) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          ev_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (key_up) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!key_up) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
endmodule

module coin_acceptor #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 8
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            key_coin5,
  input  logic            key_coin10,
  coin_acceptor_if.master bus
);
  localparam int unsigned      SUM_W   = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             ev5, ev10;
  logic             accept5_c, accept10_c, reject_c;
  logic [SUM_W-1:0] add_c, sum_c;
  logic             have5_q, have5_d;
  logic             have10_q, have10_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] rej_q, rej_d;

  coin_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb5 (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .key_n    (key_coin5),
    .press_ev (ev5)
  );

  coin_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb10 (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .key_n    (key_coin10),
    .press_ev (ev10)
  );

  // A lone event while idle is a coin; simultaneous events or a busy machine are one reject.
  assign accept5_c  = ev5 && !ev10 && !bus.busy;
  assign accept10_c = ev10 && !ev5 && !bus.busy;
  assign reject_c   = (ev5 || ev10) && !(accept5_c || accept10_c);

  always_comb begin
    have5_d  = accept5_c;
    have10_d = accept10_c;
    total_d  = total_q;
    rej_d    = rej_q;
    add_c    = '0;
    if (accept5_c) begin
      add_c = SUM_W'(5);
    end else if (accept10_c) begin
      add_c = SUM_W'(10);
    end
    sum_c = {1'b0, total_q} + add_c;
    if (accept5_c || accept10_c) begin
      total_d = sum_c[CNT_W] ? CNT_MAX : sum_c[CNT_W-1:0];
    end
    if (reject_c && (rej_q != CNT_MAX)) begin
      rej_d = rej_q + CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      have5_q  <= 1'b0;
      have10_q <= 1'b0;
      total_q  <= '0;
      rej_q    <= '0;
    end else begin
      have5_q  <= have5_d;
      have10_q <= have10_d;
      total_q  <= total_d;
      rej_q    <= rej_d;
    end
  end

  assign bus.have_coin5  = have5_q;
  assign bus.have_coin10 = have10_q;
  assign bus.coin_total  = total_q;
  assign bus.reject_cnt  = rej_q;
endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: vector table plus latency, bounce, reset and saturation sequences.
module tb_coin_acceptor;
  localparam int unsigned DEB = 4;
  localparam int unsigned CW  = 8;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic key_coin5 = 1'b1;
  logic key_coin10 = 1'b1;

  coin_acceptor_if #(.CNT_W(CW)) bus ();

  coin_acceptor #(.DEBOUNCE_CYCLES(DEB), .CNT_W(CW)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key_coin5  (key_coin5),
    .key_coin10 (key_coin10),
    .bus        (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int n5 = 0, n10 = 0, both_hi = 0, long_hi = 0;
  logic prev5 = 1'b0, prev10 = 1'b0;

  // Pulse monitor sampled on the inactive edge.
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      prev5  = 1'b0;
      prev10 = 1'b0;
    end else begin
      if (bus.have_coin5) n5++;
      if (bus.have_coin10) n10++;
      if (bus.have_coin5 && bus.have_coin10) both_hi++;
      if ((bus.have_coin5 && prev5) || (bus.have_coin10 && prev10)) long_hi++;
      prev5  = bus.have_coin5;
      prev10 = bus.have_coin10;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input logic k5, input logic k10, input logic bsy, input int hold, input int idle);
    @(negedge sys_clk);
    bus.busy   = bsy;
    key_coin5  = ~k5;
    key_coin10 = ~k10;
    repeat (hold) @(negedge sys_clk);
    key_coin5  = 1'b1;
    key_coin10 = 1'b1;
    repeat (idle) @(negedge sys_clk);
    bus.busy = 1'b0;
    #2;
  endtask

  typedef struct {
    logic k5;
    logic k10;
    logic busy;
    int   hold;
    int   exp_n5;
    int   exp_n10;
    int   exp_total;
    int   exp_rej;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  initial begin
    int b5, b10, lat;

    // Cumulative expectations, starting after the latency sequence (total 5, rejects 0).
    vecs[0] = '{1'b1, 1'b0, 1'b1, 10, 0, 0,  5, 1};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 10, 1, 0, 10, 1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 10, 0, 0, 10, 2};
    vecs[3] = '{1'b0, 1'b1, 1'b0,  3, 0, 0, 10, 2};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 10, 0, 1, 20, 2};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 10, 0, 0, 20, 3};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 10, 0, 0, 20, 4};

    bus.busy = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("reset have_coin5", int'(bus.have_coin5), 0);
    check("reset have_coin10", int'(bus.have_coin10), 0);
    check("reset coin_total", int'(bus.coin_total), 0);
    check("reset reject_cnt", int'(bus.reject_cnt), 0);
    sys_rst = 1'b0;
    repeat (5) @(negedge sys_clk);

    // Latency: key low first sampled at edge k, pulse visible after edge k+7.
    lat = -1;
    b5 = n5;
    key_coin5 = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge sys_clk);
      if (bus.have_coin5 && lat < 0) lat = j;
    end
    key_coin5 = 1'b1;
    repeat (12) @(negedge sys_clk);
    #2;
    check("latency have_coin5", lat, 7);
    check("single press pulses", n5 - b5, 1);
    check("single press total", int'(bus.coin_total), 5);
    check("single press rejects", int'(bus.reject_cnt), 0);

    for (int i = 0; i < NV; i++) begin
      b5 = n5;
      b10 = n10;
      press(vecs[i].k5, vecs[i].k10, vecs[i].busy, vecs[i].hold, 12);
      check($sformatf("vec%0d have_coin5 pulses", i), n5 - b5, vecs[i].exp_n5);
      check($sformatf("vec%0d have_coin10 pulses", i), n10 - b10, vecs[i].exp_n10);
      check($sformatf("vec%0d coin_total", i), int'(bus.coin_total), vecs[i].exp_total);
      check($sformatf("vec%0d reject_cnt", i), int'(bus.reject_cnt), vecs[i].exp_rej);
    end

    // Bouncing 10-unit key: low2 high1 low2 high1, then a solid press.
    b10 = n10;
    @(negedge sys_clk);
    key_coin10 = 1'b0; repeat (2) @(negedge sys_clk);
    key_coin10 = 1'b1; repeat (1) @(negedge sys_clk);
    key_coin10 = 1'b0; repeat (2) @(negedge sys_clk);
    key_coin10 = 1'b1; repeat (1) @(negedge sys_clk);
    #2;
    check("bounce no pulse", n10 - b10, 0);
    press(1'b0, 1'b1, 1'b0, 10, 12);
    check("bounce then hold pulses", n10 - b10, 1);
    check("bounce total", int'(bus.coin_total), 30);

    // Reset mid PRESS_WAIT with the key held through reset release.
    @(negedge sys_clk);
    key_coin5 = 1'b0;
    repeat (4) @(negedge sys_clk);
    sys_rst = 1'b1;
    #1;
    check("async reset coin_total", int'(bus.coin_total), 0);
    check("async reset reject_cnt", int'(bus.reject_cnt), 0);
    check("async reset have_coin5", int'(bus.have_coin5), 0);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    b5 = n5;
    repeat (30) @(negedge sys_clk);
    #2;
    check("held through reset pulses", n5 - b5, 0);
    check("held through reset total", int'(bus.coin_total), 0);
    @(negedge sys_clk);
    key_coin5 = 1'b1;
    repeat (12) @(negedge sys_clk);
    press(1'b1, 1'b0, 1'b0, 10, 12);
    check("re-press after reset pulses", n5 - b5, 1);
    check("re-press after reset total", int'(bus.coin_total), 5);

    // Saturation of coin_total from zero with 10-unit coins.
    @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (5) @(negedge sys_clk);
    b10 = n10;
    for (int p = 1; p <= 26; p++) begin
      press(1'b0, 1'b1, 1'b0, 8, 10);
      if (p == 25) check("total after 25 presses", int'(bus.coin_total), 250);
    end
    check("total saturated at 26", int'(bus.coin_total), 255);
    check("pulses through saturation", n10 - b10, 26);
    press(1'b0, 1'b1, 1'b0, 8, 10);
    check("total stays saturated", int'(bus.coin_total), 255);
    check("pulse while saturated", n10 - b10, 27);
    check("saturation rejects", int'(bus.reject_cnt), 0);

    check("both pulses high together", both_hi, 0);
    check("pulse longer than one cycle", long_hi, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
